// File: rtl/bk_rr_arbiter_if.sv
// Register-access request channel: valid/ready handshake plus address, write data/strobes and read data.
// The requester drives the master modport, the responder the slave modport.
interface bk_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  valid;
    logic                  rd_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  ready;
    logic [31:0]           rdata;

    modport master (
        output valid, rd_wr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, rd_wr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/bk_rr_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the backend register port; latency: valid -> t_valid 1 cycle, -> m*_ready >= 2.
// Backpressure: one transaction in flight (IDLE/BUSY/RESP); the loser waits with valid held, a silent target is cut off after TIMEOUT cycles.
module bk_rr_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int TIMEOUT    = 255
) (
    input  logic               axi_aclk,
    input  logic               axi_areset,
    bk_rr_arbiter_if.slave     m0,
    bk_rr_arbiter_if.slave     m1,
    bk_rr_arbiter_if.master    t,
    input  logic               err_clr,
    output logic               timeout_err,
    output logic               arb_busy,
    output logic               arb_gnt
);
    localparam int              CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rd_wr_q, rd_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           rsp_q, rsp_d;
    logic                  gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;

    logic                  pick;
    logic                  sel_rd_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [31:0]           sel_wdata;
    logic [3:0]            sel_wstrb;
    logic                  m0_rdy;
    logic                  m1_rdy;

    // Tie goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        pick      = (m0.valid && m1.valid) ? ~last_q : m1.valid;
        sel_rd_wr = pick ? m1.rd_wr : m0.rd_wr;
        sel_addr  = pick ? m1.addr  : m0.addr;
        sel_wdata = pick ? m1.wdata : m0.wdata;
        sel_wstrb = pick ? m1.wstrb : m0.wstrb;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_wr_d = rd_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rsp_d   = rsp_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        err_d   = err_clr ? 1'b0 : err_q;

        unique case (state_q)
            S_IDLE: begin
                if (m0.valid || m1.valid) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    rd_wr_d = sel_rd_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_rd_wr ? 32'h0 : sel_wdata;
                    wstrb_d = sel_rd_wr ? 4'h0  : sel_wstrb;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (t.ready) begin
                    rsp_d   = rd_wr_q ? t.rdata : 32'h0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_d   = rd_wr_q ? 32'hFFFF_FFFF : 32'h0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rsp_q   <= '0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_wr_q <= rd_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rsp_q   <= rsp_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign m0_rdy = (state_q == S_RESP) && !gnt_q;
    assign m1_rdy = (state_q == S_RESP) &&  gnt_q;

    assign m0.ready = m0_rdy;
    assign m0.rdata = m0_rdy ? rsp_q : 32'h0;
    assign m1.ready = m1_rdy;
    assign m1.rdata = m1_rdy ? rsp_q : 32'h0;

    assign t.valid = (state_q == S_BUSY);
    assign t.rd_wr = rd_wr_q;
    assign t.addr  = addr_q;
    assign t.wdata = wdata_q;
    assign t.wstrb = wstrb_q;

    assign timeout_err = err_q;
    assign arb_busy    = (state_q != S_IDLE);
    assign arb_gnt     = gnt_q;
endmodule

// File: tb/tb_bk_rr_arbiter.sv
// Directed bench for bk_rr_arbiter: per-cycle vector table plus hand-written timeout and contention sequences.
module tb_bk_rr_arbiter;
    logic axi_aclk   = 1'b0;
    logic axi_areset = 1'b1;
    logic err_clr    = 1'b0;
    logic timeout_err, arb_busy, arb_gnt;

    bk_rr_arbiter_if #(.ADDR_WIDTH(15)) m0_if ();
    bk_rr_arbiter_if #(.ADDR_WIDTH(15)) m1_if ();
    bk_rr_arbiter_if #(.ADDR_WIDTH(15)) t_if ();

    bk_rr_arbiter #(.ADDR_WIDTH(15), .TIMEOUT(8)) dut (
        .axi_aclk    (axi_aclk),
        .axi_areset  (axi_areset),
        .m0          (m0_if),
        .m1          (m1_if),
        .t           (t_if),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .arb_busy    (arb_busy),
        .arb_gnt     (arb_gnt)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [1:0]  rw;
        logic [14:0] a0;
        logic [31:0] d0;
        logic [14:0] a1;
        logic [31:0] d1;
        logic [3:0]  ws;
        logic        trdy;
        logic [31:0] trd;
        logic        clr;
        logic        etv;
        logic        etrw;
        logic [14:0] eta;
        logic [31:0] etwd;
        logic [3:0]  etws;
        logic [1:0]  erdy;
        logic [31:0] erd;
        logic        eerr;
        logic        ebusy;
        logic        egnt;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];
    int   n_vec = 0;
    int   n_miss = 0;
    int   exp_order [4] = '{0, 1, 0, 1};

    function automatic vec_t mk(
        input logic rst, input logic [1:0] vld, input logic [1:0] rw,
        input logic [14:0] a0, input logic [31:0] d0, input logic [14:0] a1, input logic [31:0] d1,
        input logic [3:0] ws, input logic trdy, input logic [31:0] trd, input logic clr,
        input logic etv, input logic etrw, input logic [14:0] eta, input logic [31:0] etwd, input logic [3:0] etws,
        input logic [1:0] erdy, input logic [31:0] erd, input logic eerr, input logic ebusy, input logic egnt);
        vec_t v;
        v.rst = rst;   v.vld = vld;   v.rw = rw;     v.a0 = a0;     v.d0 = d0;
        v.a1 = a1;     v.d1 = d1;     v.ws = ws;     v.trdy = trdy; v.trd = trd;
        v.clr = clr;   v.etv = etv;   v.etrw = etrw; v.eta = eta;   v.etwd = etwd;
        v.etws = etws; v.erdy = erdy; v.erd = erd;   v.eerr = eerr; v.ebusy = ebusy;
        v.egnt = egnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        axi_areset     = v.rst;
        m0_if.valid    = v.vld[0];
        m0_if.rd_wr    = v.rw[0];
        m0_if.addr     = v.a0;
        m0_if.wdata    = v.d0;
        m0_if.wstrb    = v.ws;
        m1_if.valid    = v.vld[1];
        m1_if.rd_wr    = v.rw[1];
        m1_if.addr     = v.a1;
        m1_if.wdata    = v.d1;
        m1_if.wstrb    = v.ws;
        t_if.ready     = v.trdy;
        t_if.rdata     = v.trd;
        err_clr        = v.clr;
    endtask

    task automatic run_timeout(input string tag, input logic rd, input logic [31:0] exp_rd);
        int  tv_cnt;
        logic hit;
        tv_cnt = 0;
        hit    = 1'b0;
        m0_if.valid = 1'b1;
        m0_if.rd_wr = rd;
        m0_if.addr  = 15'h0040;
        m0_if.wdata = 32'h0000_0009;
        m0_if.wstrb = 4'hF;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge axi_aclk); #1;
            if (t_if.valid) tv_cnt++;
            if (m0_if.ready) hit = 1'b1;
        end
        chk({tag, "_ready_seen"}, 32'(hit), 32'd1);
        chk({tag, "_tvalid_cycles"}, 32'(tv_cnt), 32'd8);
        chk({tag, "_m0_rdata"}, m0_if.rdata, exp_rd);
        chk({tag, "_m1_ready"}, 32'(m1_if.ready), 32'd0);
        chk({tag, "_err_set"}, 32'(timeout_err), 32'd1);
        m0_if.valid = 1'b0;
    endtask

    initial begin
        logic hit;
        int   n_gnt, n_rdy, both;

        // rst vld rw a0 d0 a1 d1 ws | trdy trd clr || etv etrw eta etwd etws erdy erd eerr ebusy egnt
        tbl[0]  = mk(1, 2'b00, 2'b00, 15'h0, 32'h0, 15'h0, 32'h0, 4'h0, 0, 32'h0, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 32'h0, 0, 0, 0);
        tbl[1]  = mk(0, 2'b01, 2'b00, 15'h0010, 32'hA5A5_5A5A, 15'h0, 32'h0, 4'hF, 0, 32'h0, 0,  1, 0, 15'h0010, 32'hA5A5_5A5A, 4'hF, 2'b00, 32'h0, 0, 1, 0);
        tbl[2]  = mk(0, 2'b01, 2'b00, 15'h0010, 32'hA5A5_5A5A, 15'h0, 32'h0, 4'hF, 1, 32'h0BAD_0BAD, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b01, 32'h0, 0, 1, 0);
        tbl[3]  = mk(0, 2'b00, 2'b00, 15'h0, 32'h0, 15'h0, 32'h0, 4'h0, 0, 32'h0, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 32'h0, 0, 0, 0);
        tbl[4]  = mk(0, 2'b10, 2'b10, 15'h1111, 32'h2222_2222, 15'h7FFC, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0,  1, 1, 15'h7FFC, 32'h0, 4'h0, 2'b00, 32'h0, 0, 1, 1);
        tbl[5]  = mk(0, 2'b10, 2'b10, 15'h1111, 32'h2222_2222, 15'h7FFC, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0,  1, 1, 15'h7FFC, 32'h0, 4'h0, 2'b00, 32'h0, 0, 1, 1);
        tbl[6]  = mk(0, 2'b10, 2'b10, 15'h1111, 32'h2222_2222, 15'h7FFC, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 0,  1, 1, 15'h7FFC, 32'h0, 4'h0, 2'b00, 32'h0, 0, 1, 1);
        tbl[7]  = mk(0, 2'b10, 2'b10, 15'h1111, 32'h2222_2222, 15'h7FFC, 32'hDEAD_BEEF, 4'hF, 1, 32'h1234_5678, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b10, 32'h1234_5678, 0, 1, 1);
        tbl[8]  = mk(0, 2'b00, 2'b00, 15'h0, 32'h0, 15'h0, 32'h0, 4'h0, 0, 32'h0, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 32'h0, 0, 0, 1);
        tbl[9]  = mk(0, 2'b01, 2'b00, 15'h0123, 32'h1111_2222, 15'h0, 32'h0, 4'h3, 0, 32'h0, 0,  1, 0, 15'h0123, 32'h1111_2222, 4'h3, 2'b00, 32'h0, 0, 1, 0);
        tbl[10] = mk(0, 2'b01, 2'b00, 15'h0456, 32'h3333_4444, 15'h0, 32'h0, 4'hC, 0, 32'h0, 0,  1, 0, 15'h0123, 32'h1111_2222, 4'h3, 2'b00, 32'h0, 0, 1, 0);
        tbl[11] = mk(0, 2'b01, 2'b00, 15'h0456, 32'h3333_4444, 15'h0, 32'h0, 4'hC, 1, 32'h5555_5555, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b01, 32'h0, 0, 1, 0);
        tbl[12] = mk(0, 2'b00, 2'b00, 15'h0, 32'h0, 15'h0, 32'h0, 4'h0, 0, 32'h0, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 32'h0, 0, 0, 0);
        tbl[13] = mk(0, 2'b01, 2'b01, 15'h0200, 32'hCAFE_F00D, 15'h0, 32'h0, 4'hF, 0, 32'h0, 0,  1, 1, 15'h0200, 32'h0, 4'h0, 2'b00, 32'h0, 0, 1, 0);
        tbl[14] = mk(0, 2'b01, 2'b01, 15'h0200, 32'hCAFE_F00D, 15'h0, 32'h0, 4'hF, 0, 32'h0, 0,  1, 1, 15'h0200, 32'h0, 4'h0, 2'b00, 32'h0, 0, 1, 0);
        tbl[15] = mk(1, 2'b01, 2'b01, 15'h0200, 32'hCAFE_F00D, 15'h0, 32'h0, 4'hF, 1, 32'h9999_9999, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 32'h0, 0, 0, 0);
        tbl[16] = mk(0, 2'b11, 2'b00, 15'h0AAA, 32'h0A0A_0A0A, 15'h0BBB, 32'h0B0B_0B0B, 4'hF, 0, 32'h0, 0,  1, 0, 15'h0AAA, 32'h0A0A_0A0A, 4'hF, 2'b00, 32'h0, 0, 1, 0);
        tbl[17] = mk(0, 2'b11, 2'b00, 15'h0AAA, 32'h0A0A_0A0A, 15'h0BBB, 32'h0B0B_0B0B, 4'hF, 1, 32'h0, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b01, 32'h0, 0, 1, 0);
        tbl[18] = mk(0, 2'b00, 2'b00, 15'h0, 32'h0, 15'h0, 32'h0, 4'h0, 0, 32'h0, 0,  0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 32'h0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i]);
            @(posedge axi_aclk); #1;
            chk($sformatf("v%0d_t_valid", i), 32'(t_if.valid), 32'(tbl[i].etv));
            if (tbl[i].etv) begin
                chk($sformatf("v%0d_t_rd_wr", i), 32'(t_if.rd_wr), 32'(tbl[i].etrw));
                chk($sformatf("v%0d_t_addr", i),  32'(t_if.addr),  32'(tbl[i].eta));
                chk($sformatf("v%0d_t_wdata", i), t_if.wdata,      tbl[i].etwd);
                chk($sformatf("v%0d_t_wstrb", i), 32'(t_if.wstrb), 32'(tbl[i].etws));
            end
            chk($sformatf("v%0d_m0_ready", i), 32'(m0_if.ready), 32'(tbl[i].erdy[0]));
            chk($sformatf("v%0d_m1_ready", i), 32'(m1_if.ready), 32'(tbl[i].erdy[1]));
            chk($sformatf("v%0d_m0_rdata", i), m0_if.rdata, tbl[i].erdy[0] ? tbl[i].erd : 32'h0);
            chk($sformatf("v%0d_m1_rdata", i), m1_if.rdata, tbl[i].erdy[1] ? tbl[i].erd : 32'h0);
            chk($sformatf("v%0d_timeout_err", i), 32'(timeout_err), 32'(tbl[i].eerr));
            chk($sformatf("v%0d_arb_busy", i), 32'(arb_busy), 32'(tbl[i].ebusy));
            chk($sformatf("v%0d_arb_gnt", i), 32'(arb_gnt), 32'(tbl[i].egnt));
        end

        // Timeout on a read, then a late target answer in IDLE, then err_clr.
        run_timeout("to_read", 1'b1, 32'hFFFF_FFFF);
        t_if.ready = 1'b1;
        t_if.rdata = 32'h7777_7777;
        for (int c = 0; c < 2; c++) begin
            @(posedge axi_aclk); #1;
            chk($sformatf("late%0d_busy", c), 32'(arb_busy), 32'd0);
            chk($sformatf("late%0d_t_valid", c), 32'(t_if.valid), 32'd0);
            chk($sformatf("late%0d_m0_ready", c), 32'(m0_if.ready), 32'd0);
            chk($sformatf("late%0d_err_sticky", c), 32'(timeout_err), 32'd1);
        end
        t_if.ready = 1'b0;
        err_clr    = 1'b1;
        @(posedge axi_aclk); #1;
        err_clr = 1'b0;
        chk("err_clr_clears", 32'(timeout_err), 32'd0);

        // Second timeout (write) with err_clr held high: set wins over clear.
        err_clr = 1'b1;
        run_timeout("to_write", 1'b0, 32'h0);
        err_clr = 1'b0;
        @(posedge axi_aclk); #1;
        chk("err_after_clr_release", 32'(timeout_err), 32'd1);

        // Contention from reset: both valid held high, target always ready.
        axi_areset  = 1'b1;
        m0_if.valid = 1'b1; m0_if.rd_wr = 1'b0; m0_if.addr = 15'h00A0; m0_if.wdata = 32'hA0; m0_if.wstrb = 4'hF;
        m1_if.valid = 1'b1; m1_if.rd_wr = 1'b0; m1_if.addr = 15'h00B1; m1_if.wdata = 32'hB1; m1_if.wstrb = 4'hF;
        t_if.ready  = 1'b1;
        t_if.rdata  = 32'h0;
        @(posedge axi_aclk); #1;
        chk("cont_reset_err", 32'(timeout_err), 32'd0);
        axi_areset = 1'b0;
        n_gnt = 0; n_rdy = 0; both = 0; hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge axi_aclk); #1;
            if (t_if.valid && n_gnt < 4) begin
                chk($sformatf("cont_gnt%0d", n_gnt), 32'(arb_gnt), 32'(exp_order[n_gnt]));
                chk($sformatf("cont_addr%0d", n_gnt), 32'(t_if.addr), exp_order[n_gnt] == 1 ? 32'h00B1 : 32'h00A0);
                n_gnt++;
            end
            if (m0_if.ready && m1_if.ready) both++;
            if ((m0_if.ready || m1_if.ready) && n_rdy < 4) begin
                chk($sformatf("cont_rdy%0d", n_rdy), 32'(m1_if.ready), 32'(exp_order[n_rdy]));
                n_rdy++;
                if (n_rdy == 4) hit = 1'b1;
            end
        end
        chk("cont_done", 32'(n_rdy), 32'd4);
        chk("cont_both_ready", 32'(both), 32'd0);
        m0_if.valid = 1'b0;
        m1_if.valid = 1'b0;
        t_if.ready  = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
